// File: rtl/maxpool_pkg.sv
// Shared types and defaults for the 2x2/stride-2 max-pool sequencer.
// Holds the FSM state enum, default sizes and an unsigned max helper.
package maxpool_pkg;

    localparam int MP_BITS = 8;
    localparam int MP_DIM  = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        DRAIN,
        DONE
    } mp_state_t;

    function automatic logic [MP_BITS-1:0] umax(
        input logic [MP_BITS-1:0] a,
        input logic [MP_BITS-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_max2.sv
// Combinational unsigned max of two BITS-wide words; ties give the equal value.
// Ports: a_i, b_i operands; y_o the larger.
module maxpool_max2 #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    output logic [BITS-1:0] y_o
);

    assign y_o = (a_i >= b_i) ? a_i : b_i;

endmodule

// File: rtl/maxpool_seq_ctrl.sv
// Sequences a 2x2/stride-2 max-pool from an input SRAM to an output SRAM,
// streaming row pairs through a DIM/2-entry line buffer.
// Ports: start/busy/done command side; in_rd_* input SRAM read port
// (data one cycle after in_rd_en); out_wr_* output SRAM valid/ready write.
module maxpool_seq_ctrl
    import maxpool_pkg::*;
#(
    parameter int BITS = MP_BITS,
    parameter int DIM  = MP_DIM,
    parameter int AW   = $clog2(DIM*DIM),
    parameter int OAW  = $clog2(DIM*DIM/4)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            in_rd_en,
    output logic [AW-1:0]   in_rd_addr,
    input  logic [BITS-1:0] in_rd_data,
    output logic            out_wr_en,
    output logic [OAW-1:0]  out_wr_addr,
    output logic [BITS-1:0] out_wr_data,
    input  logic            out_wr_ready
);

    localparam int CW = $clog2(DIM);
    localparam int RW = $clog2(DIM/2);

    mp_state_t state_q, state_d;

    logic [CW-1:0]   col_q;
    logic [RW-1:0]   pr_q;
    logic [OAW-1:0]  oaddr_q;
    logic            rd_vld_q;
    logic            rd_ph_q;
    logic [CW-1:0]   rd_col_q;
    logic [BITS-1:0] hold_q;
    logic [BITS-1:0] out_q;
    logic            ov_q;
    logic [BITS-1:0] lb_q [DIM/2];

    logic [CW-2:0]   lb_idx;
    logic [BITS-1:0] pair_max;
    logic [BITS-1:0] row_max;
    logic            in_rd1;
    logic            last_col;
    logic            last_pair;
    logic            accept;
    logic            stall;
    logic            issue;

    assign in_rd1    = (state_q == RD1);
    assign last_col  = (col_q == CW'(DIM-1));
    assign last_pair = (pr_q == RW'(DIM/2-1));
    assign accept    = ov_q && out_wr_ready;
    assign lb_idx    = rd_col_q[CW-1:1];

    // An odd-column read in RD1 refills the out reg two cycles later;
    // hold it back while the current word is still waiting.
    assign stall = in_rd1 && col_q[0] && ov_q && !out_wr_ready;
    assign issue = ((state_q == RD0) || in_rd1) && !stall;

    maxpool_max2 #(.BITS(BITS)) u_pair (
        .a_i (hold_q),
        .b_i (in_rd_data),
        .y_o (pair_max)
    );

    maxpool_max2 #(.BITS(BITS)) u_row (
        .a_i (pair_max),
        .b_i (lb_q[lb_idx]),
        .y_o (row_max)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = RD0;
            RD0:   if (issue && last_col) state_d = RD1;
            RD1:   if (issue && last_col)
                       state_d = last_pair ? DRAIN : RD0;
            DRAIN: if (!rd_vld_q && (!ov_q || out_wr_ready))
                       state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        in_rd_en   = issue;
        in_rd_addr = AW'({pr_q, in_rd1}) * AW'(DIM) + AW'(col_q);
    end

    assign out_wr_en   = ov_q;
    assign out_wr_addr = oaddr_q;
    assign out_wr_data = out_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q    <= '0;
            pr_q     <= '0;
            oaddr_q  <= '0;
            rd_vld_q <= 1'b0;
            rd_ph_q  <= 1'b0;
            rd_col_q <= '0;
            hold_q   <= '0;
            out_q    <= '0;
            ov_q     <= 1'b0;
        end else begin
            rd_vld_q <= issue;
            rd_ph_q  <= in_rd1;
            rd_col_q <= col_q;
            if (state_q == IDLE) begin
                col_q   <= '0;
                pr_q    <= '0;
                oaddr_q <= '0;
            end else if (issue) begin
                if (last_col) begin
                    col_q <= '0;
                    if (in_rd1) pr_q <= pr_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            if (accept) oaddr_q <= oaddr_q + 1'b1;
            if (rd_vld_q && !rd_col_q[0]) hold_q <= in_rd_data;
            // A load and an accept in the same cycle keep the reg full.
            if (rd_vld_q && rd_col_q[0] && rd_ph_q) begin
                out_q <= row_max;
                ov_q  <= 1'b1;
            end else if (accept) begin
                ov_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && rd_vld_q && rd_col_q[0] && !rd_ph_q)
            lb_q[lb_idx] <= pair_max;
    end

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Self-checking bench for maxpool_seq_ctrl at DIM=32 and DIM=4.
// Table-driven output checks plus directed multi-cycle sequences.
module tb_maxpool_seq_ctrl;
    import maxpool_pkg::*;

    localparam int D  = 32;
    localparam int N  = D*D;
    localparam int NO = N/4;

    typedef struct {
        int         pat;
        int         idx;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, start4;
    logic       busy, done, rd_en, wr_en, wr_ready;
    logic [9:0] rd_addr;
    logic [7:0] rd_data, wr_addr, wr_data;
    logic       busy4, done4, rd_en4, wr_en4, wr_ready4;
    logic [3:0] rd_addr4;
    logic [1:0] wr_addr4;
    logic [7:0] rd_data4, wr_data4;

    maxpool_seq_ctrl #(.BITS(8), .DIM(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done),
        .in_rd_en(rd_en), .in_rd_addr(rd_addr), .in_rd_data(rd_data),
        .out_wr_en(wr_en), .out_wr_addr(wr_addr),
        .out_wr_data(wr_data), .out_wr_ready(wr_ready)
    );

    maxpool_seq_ctrl #(.BITS(8), .DIM(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .busy(busy4), .done(done4),
        .in_rd_en(rd_en4), .in_rd_addr(rd_addr4), .in_rd_data(rd_data4),
        .out_wr_en(wr_en4), .out_wr_addr(wr_addr4),
        .out_wr_data(wr_data4), .out_wr_ready(wr_ready4)
    );

    logic [7:0] mem  [N];
    logic [7:0] mem4 [16];
    logic [7:0] got  [NO];
    logic [7:0] got4 [4];
    logic [7:0] expv [NO];
    vec_t       tbl  [$];

    int cyc = 0;
    int s_cyc = 0;
    int nwr, order_err, stall_err, ndone, last_wr_cyc;
    int nwr4, order_err4;
    int rmode, lowcnt;
    int passed = 0;
    int total  = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en)  rd_data  <= mem[rd_addr];
        if (rd_en4) rd_data4 <= mem4[rd_addr4];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en && wr_ready) begin
                if (int'(wr_addr) != nwr) order_err <= order_err + 1;
                got[wr_addr] <= wr_data;
                nwr          <= nwr + 1;
                last_wr_cyc  <= cyc - s_cyc + 1;
            end
            if (rd_en && rd_addr[0] && rd_addr[5] && wr_en && !wr_ready)
                stall_err <= stall_err + 1;
            if (done) ndone <= ndone + 1;
            if (wr_en4 && wr_ready4) begin
                if (int'(wr_addr4) != nwr4) order_err4 <= order_err4 + 1;
                got4[wr_addr4] <= wr_data4;
                nwr4           <= nwr4 + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic drive_ready();
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0)
                wr_ready = 1'b1;
            else if (nwr >= 40 && lowcnt < 10) begin
                wr_ready = 1'b0;
                lowcnt++;
            end else if (nwr >= 40)
                wr_ready = 1'($urandom_range(0, 1));
            else
                wr_ready = 1'b1;
        end
    endtask

    function automatic void build_model();
        for (int r = 0; r < D/2; r++)
            for (int c = 0; c < D/2; c++) begin
                int a = 2*r*D + 2*c;
                expv[r*(D/2)+c] = umax(umax(mem[a], mem[a+1]),
                                       umax(mem[a+D], mem[a+D+1]));
            end
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after done.
    task automatic do_pass(input bit glitch, output int dcyc);
        nwr = 0; order_err = 0; stall_err = 0; lowcnt = 0;
        build_model();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_cyc = cyc;
        dcyc  = -1;
        for (int k = 0; k < 20000 && dcyc < 0; k++) begin
            @(negedge clk);
            if (done) dcyc = cyc - s_cyc + 1;
            if (glitch) start = done || k == 100 || k == 500;
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("done_seen", int'(dcyc > 0), 1);
    endtask

    task automatic check_all(input string tag);
        int mm = 0;
        for (int i = 0; i < NO; i++) if (got[i] != expv[i]) mm++;
        check({tag, "_data"}, mm, 0);
        check({tag, "_nwr"}, nwr, NO);
        check({tag, "_order"}, order_err, 0);
    endtask

    task automatic apply_tbl(input int p);
        foreach (tbl[i]) if (tbl[i].pat == p) begin
            int act = (p == 3) ? int'(got4[tbl[i].idx])
                               : int'(got[tbl[i].idx]);
            check($sformatf("tbl_p%0d_i%0d", p, tbl[i].idx),
                  act, int'(tbl[i].exp));
        end
    endtask

    initial begin
        int dc;
        bit hit;

        // pat 0: ramp, 1: one-hot (5,9), 2: all 8'hFF, 3: DIM=4 ramp+16
        tbl.push_back('{0,   0, 8'd33});
        tbl.push_back('{0,   1, 8'd35});
        tbl.push_back('{0,  15, 8'd63});
        tbl.push_back('{0,  16, 8'd97});
        tbl.push_back('{0,  53, 8'd235});
        tbl.push_back('{0,  64, 8'd33});
        tbl.push_back('{0, 130, 8'd37});
        tbl.push_back('{0, 255, 8'd255});
        tbl.push_back('{1,  36, 8'hFF});
        tbl.push_back('{1,  35, 8'h00});
        tbl.push_back('{1,  37, 8'h00});
        tbl.push_back('{1,  20, 8'h00});
        tbl.push_back('{1,   0, 8'h00});
        tbl.push_back('{2,   0, 8'hFF});
        tbl.push_back('{2, 255, 8'hFF});
        tbl.push_back('{3,   0, 8'd21});
        tbl.push_back('{3,   1, 8'd23});
        tbl.push_back('{3,   2, 8'd29});
        tbl.push_back('{3,   3, 8'd31});

        rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
        wr_ready = 1'b1; wr_ready4 = 1'b1;
        rmode = 0; ndone = 0; nwr4 = 0; order_err4 = 0;
        nwr = 0; order_err = 0; stall_err = 0; lowcnt = 0;
        fork drive_ready(); join_none
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", int'({busy, done, rd_en, wr_en}), 0);
        check("reset_addr", int'({rd_addr, wr_addr, wr_data}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ramp, full throughput
        for (int a = 0; a < N; a++) mem[a] = 8'(a);
        do_pass(1'b0, dc);
        check("ramp_done_cyc", dc, 1027);
        check("ramp_last_wr", last_wr_cyc, 1026);
        check_all("ramp");
        apply_tbl(0);

        // single hot pixel at (5,9)
        for (int a = 0; a < N; a++) mem[a] = 8'h00;
        mem[5*D+9] = 8'hFF;
        do_pass(1'b0, dc);
        check_all("onehot");
        apply_tbl(1);

        for (int a = 0; a < N; a++) mem[a] = 8'hFF;
        do_pass(1'b0, dc);
        check_all("allff");
        apply_tbl(2);

        // backpressure: stalled at index 40, then random ready
        for (int a = 0; a < N; a++) mem[a] = 8'($urandom);
        rmode = 1;
        do_pass(1'b0, dc);
        rmode = 0;
        check_all("bp");
        check("bp_stall_rule", stall_err, 0);

        // reset while reading row 7
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            @(negedge clk);
            if (rd_en && int'(rd_addr) >= 7*D) hit = 1'b1;
        end
        check("rst_row7_reached", int'(hit), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_ctl", int'({busy, done, rd_en, wr_en}), 0);
        check("midrst_addr", int'({rd_addr, wr_addr, wr_data}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < N; a++) mem[a] = 8'($urandom);
        do_pass(1'b0, dc);
        check("after_rst_done_cyc", dc, 1027);
        check_all("after_rst");

        // stray starts mid-pass and in DONE, then back-to-back passes
        ndone = 0;
        for (int a = 0; a < N; a++) mem[a] = 8'(a);
        do_pass(1'b1, dc);
        check("glitch_done_cyc", dc, 1027);
        check_all("glitch");
        repeat (3) @(posedge clk);
        #1;
        check("glitch_idle", int'(busy), 0);
        for (int a = 0; a < N; a++) mem[a] = 8'($urandom);
        do_pass(1'b0, dc);
        check_all("b2b_a");
        for (int a = 0; a < N; a++) mem[a] = 8'($urandom);
        do_pass(1'b0, dc);
        check("b2b_done_cyc", dc, 1027);
        check_all("b2b_b");
        repeat (5) @(posedge clk);
        #1;
        check("done_count", ndone, 3);

        // DIM=4 ramp offset by 16
        for (int a = 0; a < 16; a++) mem4[a] = 8'(a + 16);
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        s_cyc = cyc;
        dc = -1;
        for (int k = 0; k < 200 && dc < 0; k++) begin
            @(negedge clk);
            if (done4) dc = cyc - s_cyc + 1;
        end
        check("d4_done_cyc", dc, 19);
        check("d4_nwr", nwr4, 4);
        check("d4_order", order_err4, 0);
        apply_tbl(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
